// File: rtl/ven_panel_arbiter.sv
// Round-robin arbiter sharing one vending machine core between customer panels A and B.
// Define VEN_ARB_STATS_EN to add saturating served_a/served_b/refunds counters.
module ven_panel_arbiter #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_a,
    input  logic [4:0] money_a,
    input  logic [1:0] sel_a,
    input  logic       req_b,
    input  logic [4:0] money_b,
    input  logic [1:0] sel_b,
    input  logic       vm_news,
    input  logic       vm_choc,
    input  logic       vm_juice,
    input  logic [4:0] vm_balance,
    output logic [4:0] vm_money,
    output logic [1:0] vm_select,
    output logic       grant_a,
    output logic       grant_b,
    output logic       done_a,
    output logic       done_b,
    output logic [1:0] item_out,
    output logic [4:0] change_out,
    output logic       busy
`ifdef VEN_ARB_STATS_EN
    ,
    output logic [7:0] served_a,
    output logic [7:0] served_b,
    output logic [7:0] refunds
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic             owner_q;      // 0 = panel A, 1 = panel B
    logic             last_b_q;     // 1 when B was served last
    logic [4:0]       money_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       grant_q;      // {B, A}
    logic [1:0]       done_q;
    logic [4:0]       vm_money_q;
    logic [1:0]       vm_select_q;
    logic [1:0]       item_q;
    logic [4:0]       change_q;

    logic             pick_b_d;
    logic             any_req_d;
    logic [4:0]       pick_money_d;
    logic [1:0]       pick_sel_d;
    logic             pick_valid_d;
    logic             any_strobe_d;
    logic [1:0]       strobe_item_d;
    logic             timeout_hit_d;

    // Arbitration and dispense decode; the tie goes to whoever was not served last.
    always_comb begin
        any_req_d = req_a | req_b;
        pick_b_d  = req_b;
        if (req_a && req_b) begin
            pick_b_d = ~last_b_q;
        end
        pick_money_d = pick_b_d ? money_b : money_a;
        pick_sel_d   = pick_b_d ? sel_b   : sel_a;
        pick_valid_d = (pick_sel_d != 2'b00) && (pick_money_d != 5'd0);

        any_strobe_d  = vm_news | vm_choc | vm_juice;
        strobe_item_d = 2'b00;
        if (vm_juice) begin
            strobe_item_d = 2'b11;
        end else if (vm_choc) begin
            strobe_item_d = 2'b10;
        end else if (vm_news) begin
            strobe_item_d = 2'b01;
        end
        timeout_hit_d = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_b_q    <= 1'b1;
            money_q     <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            vm_money_q  <= '0;
            vm_select_q <= '0;
            item_q      <= '0;
            change_q    <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        owner_q <= pick_b_d;
                        grant_q <= pick_b_d ? 2'b10 : 2'b01;
                        money_q <= pick_money_d;
                        sel_q   <= pick_sel_d;
                        if (pick_valid_d) begin
                            state_q     <= S_LOAD;
                            vm_money_q  <= pick_money_d;
                            vm_select_q <= pick_sel_d;
                        end else begin
                            // Unusable request: hand the money straight back, core untouched.
                            state_q  <= S_DONE;
                            item_q   <= 2'b00;
                            change_q <= pick_money_d;
                            done_q   <= pick_b_d ? 2'b10 : 2'b01;
                        end
                    end
                end
                S_LOAD: begin
                    vm_money_q  <= '0;
                    vm_select_q <= '0;
                    cnt_q       <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (any_strobe_d) begin
                        item_q   <= strobe_item_d;
                        change_q <= vm_balance;
                        done_q   <= grant_q;
                        state_q  <= S_DONE;
                    end else if (timeout_hit_d) begin
                        item_q   <= 2'b00;
                        change_q <= money_q;
                        done_q   <= grant_q;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    grant_q  <= '0;
                    last_b_q <= owner_q;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign vm_money   = vm_money_q;
    assign vm_select  = vm_select_q;
    assign grant_a    = grant_q[0];
    assign grant_b    = grant_q[1];
    assign done_a     = done_q[0];
    assign done_b     = done_q[1];
    assign item_out   = item_q;
    assign change_out = change_q;
    assign busy       = (state_q != S_IDLE);

`ifdef VEN_ARB_STATS_EN
    logic [7:0] served_w [2];
    logic [7:0] refunds_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_served
        logic [7:0] cnt_served_q;
        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_served_q <= '0;
            end else if (state_q == S_DONE && owner_q == 1'(gi) &&
                         item_q != 2'b00 && cnt_served_q != 8'hFF) begin
                cnt_served_q <= cnt_served_q + 8'd1;
            end
        end
        assign served_w[gi] = cnt_served_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            refunds_q <= '0;
        end else if (state_q == S_DONE && item_q == 2'b00 && refunds_q != 8'hFF) begin
            refunds_q <= refunds_q + 8'd1;
        end
    end

    assign served_a = served_w[0];
    assign served_b = served_w[1];
    assign refunds  = refunds_q;
`endif

endmodule

// File: tb/tb_ven_panel_arbiter.sv
// Directed bench for ven_panel_arbiter: hand-computed expectations, one line per transaction.
module tb_ven_panel_arbiter;

    localparam int TIMEOUT = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [4:0] money_a, money_b;
    logic [1:0] sel_a, sel_b;
    logic       vm_news, vm_choc, vm_juice;
    logic [4:0] vm_balance;
    logic [4:0] vm_money;
    logic [1:0] vm_select;
    logic       grant_a, grant_b, done_a, done_b;
    logic [1:0] item_out;
    logic [4:0] change_out;
    logic       busy;
`ifdef VEN_ARB_STATS_EN
    logic [7:0] served_a, served_b, refunds;
`endif

    int checks = 0;
    int errors = 0;

    ven_panel_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_a      (req_a),
        .money_a    (money_a),
        .sel_a      (sel_a),
        .req_b      (req_b),
        .money_b    (money_b),
        .sel_b      (sel_b),
        .vm_news    (vm_news),
        .vm_choc    (vm_choc),
        .vm_juice   (vm_juice),
        .vm_balance (vm_balance),
        .vm_money   (vm_money),
        .vm_select  (vm_select),
        .grant_a    (grant_a),
        .grant_b    (grant_b),
        .done_a     (done_a),
        .done_b     (done_b),
        .item_out   (item_out),
        .change_out (change_out),
        .busy       (busy)
`ifdef VEN_ARB_STATS_EN
        ,
        .served_a   (served_a),
        .served_b   (served_b),
        .refunds    (refunds)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Invariants sampled mid-cycle: exclusive grants, done only with its grant.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            check_eq("mutex_grant", int'(grant_a & grant_b), 0);
            check_eq("done_a_needs_grant", int'(done_a & ~grant_a), 0);
            check_eq("done_b_needs_grant", int'(done_b & ~grant_b), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        req_a = 1'b0; money_a = '0; sel_a = '0;
        req_b = 1'b0; money_b = '0; sel_b = '0;
        vm_news = 1'b0; vm_choc = 1'b0; vm_juice = 1'b0; vm_balance = '0;
        tick();
        tick();
        check_eq("rst_grant_a", int'(grant_a), 0);
        check_eq("rst_grant_b", int'(grant_b), 0);
        check_eq("rst_done", int'({done_a, done_b}), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_item", int'(item_out), 0);
        check_eq("rst_change", int'(change_out), 0);
        check_eq("rst_vm_money", int'(vm_money), 0);
        check_eq("rst_vm_select", int'(vm_select), 0);
        $display("txn reset: outputs idle");
        reset = 1'b0;
        tick();

        // Single A request, choc dispensed on the first WAIT cycle
        req_a = 1'b1; money_a = 5'd10; sel_a = 2'b10;
        tick();
        check_eq("t1_grant_a", int'(grant_a), 1);
        check_eq("t1_grant_b", int'(grant_b), 0);
        check_eq("t1_load_money", int'(vm_money), 10);
        check_eq("t1_load_sel", int'(vm_select), 2);
        check_eq("t1_busy", int'(busy), 1);
        money_a = 5'd31; sel_a = 2'b01;
        vm_news = 1'b1; vm_balance = 5'd17;     // strobe during LOAD must be ignored
        tick();
        check_eq("t1_wait_money", int'(vm_money), 0);
        check_eq("t1_wait_sel", int'(vm_select), 0);
        check_eq("t1_wait_done", int'(done_a), 0);
        vm_news = 1'b0; vm_choc = 1'b1; vm_balance = 5'd0;
        tick();
        check_eq("t1_done_a", int'(done_a), 1);
        check_eq("t1_item", int'(item_out), 2);
        check_eq("t1_change", int'(change_out), 0);
        $display("txn single A: done_a=%0d item=%0d change=%0d", done_a, item_out, change_out);
        vm_choc = 1'b0; req_a = 1'b0;
        tick();
        check_eq("t1_idle_done", int'(done_a), 0);
        check_eq("t1_idle_grant", int'(grant_a), 0);
        check_eq("t1_item_held", int'(item_out), 2);
        check_eq("t1_idle_busy", int'(busy), 0);

        // Contention from reset: A first, then B
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_a = 1'b1; money_a = 5'd5; sel_a = 2'b01;
        req_b = 1'b1; money_b = 5'd7; sel_b = 2'b11;
        tick();
        check_eq("t2_grant_a", int'(grant_a), 1);
        check_eq("t2_grant_b_low", int'(grant_b), 0);
        check_eq("t2_money_a", int'(vm_money), 5);
        tick();
        vm_news = 1'b1; vm_balance = 5'd4;
        tick();
        check_eq("t2_done_a", int'(done_a), 1);
        check_eq("t2_item_a", int'(item_out), 1);
        check_eq("t2_change_a", int'(change_out), 4);
        $display("txn contention A: item=%0d change=%0d", item_out, change_out);
        vm_news = 1'b0; req_a = 1'b0;
        tick();
        check_eq("t2_gap_grant_b", int'(grant_b), 0);
        check_eq("t2_gap_busy", int'(busy), 0);
        tick();
        check_eq("t2_grant_b", int'(grant_b), 1);
        check_eq("t2_money_b", int'(vm_money), 7);
        check_eq("t2_sel_b", int'(vm_select), 3);
        tick();
        vm_juice = 1'b1; vm_choc = 1'b1; vm_balance = 5'd3;
        tick();
        check_eq("t2_done_b", int'(done_b), 1);
        check_eq("t2_item_prio", int'(item_out), 3);
        check_eq("t2_change_b", int'(change_out), 3);
        $display("txn contention B: item=%0d change=%0d", item_out, change_out);
        vm_juice = 1'b0; vm_choc = 1'b0; req_b = 1'b0;
        tick();

        // Timeout refund on B; late money change must not affect the refund
        req_b = 1'b1; money_b = 5'd20; sel_b = 2'b11;
        tick();
        check_eq("t3_grant_b", int'(grant_b), 1);
        money_b = 5'd1;
        n = 0;
        for (int i = 0; i < 20 && done_b !== 1'b1; i++) begin
            tick();
            n++;
        end
        // n counts TIMEOUT WAIT cycles plus the DONE cycle itself
        check_eq("t3_wait_cycles", n - 1, TIMEOUT);
        check_eq("t3_item", int'(item_out), 0);
        check_eq("t3_refund", int'(change_out), 20);
        $display("txn timeout B: wait=%0d item=%0d change=%0d", n - 1, item_out, change_out);
        req_b = 1'b0;
        tick();

        // Invalid requests go straight to DONE
        req_a = 1'b1; money_a = 5'd0; sel_a = 2'b01;
        tick();
        check_eq("t4a_grant", int'(grant_a), 1);
        check_eq("t4a_done", int'(done_a), 1);
        check_eq("t4a_vm_money", int'(vm_money), 0);
        check_eq("t4a_item", int'(item_out), 0);
        check_eq("t4a_change", int'(change_out), 0);
        $display("txn invalid A money=0: item=%0d change=%0d", item_out, change_out);
        req_a = 1'b0;
        tick();
        req_a = 1'b1; money_a = 5'd9; sel_a = 2'b00;
        tick();
        check_eq("t4b_done", int'(done_a), 1);
        check_eq("t4b_vm_sel", int'(vm_select), 0);
        check_eq("t4b_change", int'(change_out), 9);
        $display("txn invalid A sel=0: item=%0d change=%0d", item_out, change_out);
        req_a = 1'b0;
        tick();

        // Reset in the middle of WAIT aborts silently, then A is re-granted
        req_a = 1'b1; money_a = 5'd10; sel_a = 2'b01;
        tick();
        tick();
        check_eq("t5_wait_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        check_eq("t5_rst_grant", int'(grant_a), 0);
        check_eq("t5_rst_done", int'(done_a), 0);
        check_eq("t5_rst_busy", int'(busy), 0);
        check_eq("t5_rst_change", int'(change_out), 0);
        check_eq("t5_rst_item", int'(item_out), 0);
        reset = 1'b0;
        tick();
        check_eq("t5_regrant", int'(grant_a), 1);
        check_eq("t5_regrant_money", int'(vm_money), 10);
        tick();
        vm_news = 1'b1; vm_balance = 5'd9;
        tick();
        check_eq("t5_done", int'(done_a), 1);
        check_eq("t5_item", int'(item_out), 1);
        check_eq("t5_change", int'(change_out), 9);
        $display("txn reset-abort A then regrant: item=%0d change=%0d", item_out, change_out);
        vm_news = 1'b0; req_a = 1'b0;
        tick();

`ifdef VEN_ARB_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("st_rst_served_a", int'(served_a), 0);
        check_eq("st_rst_refunds", int'(refunds), 0);
        for (int k = 0; k < 2; k++) begin
            req_a = 1'b1; money_a = 5'd6; sel_a = 2'b10;
            tick();
            tick();
            vm_choc = 1'b1; vm_balance = 5'd1;
            tick();
            vm_choc = 1'b0; req_a = 1'b0;
            tick();
            $display("txn stats A success %0d: served_a=%0d", k, served_a);
        end
        req_a = 1'b1; money_a = 5'd6; sel_a = 2'b10;
        tick();
        for (int i = 0; i < 20 && done_a !== 1'b1; i++) begin
            tick();
        end
        req_a = 1'b0;
        tick();
        check_eq("st_served_a", int'(served_a), 2);
        check_eq("st_served_b", int'(served_b), 0);
        check_eq("st_refunds", int'(refunds), 1);
        $display("txn stats: served_a=%0d served_b=%0d refunds=%0d", served_a, served_b, refunds);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
